branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Predicts next-PC at IF and learns from branches resolved in EX. Uses a direct-mapped
//  BTB with 2-bit saturating counters. The EX side consumes the branch-unit result
//  (BrOp, NextPCSrc, target), detects mispredicts and drives the redirect/flush to fetch.
// PARAMETERS
//  IDX_BITS  6  BTB index width; 2**IDX_BITS entries, index = pc[IDX_BITS+1:2]
//  TAG_BITS  8  partial tag width, tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous reset, active high
//  if_pc          in   32  fetch PC
//  pred_taken     out  1   predicted taken for if_pc
//  pred_target    out  32  predicted next PC (target if taken, else if_pc+4)
//  ex_valid       in   1   EX stage holds a valid instruction
//  ex_pc          in   32  PC of EX instruction
//  ex_br_op       in   5   BrOp of EX instruction ([4]=jump, [4:3]=00 non-branch)
//  ex_taken       in   1   NextPCSrc from branch unit
//  ex_target      in   32  computed branch/jump target
//  ex_pred_taken  in   1   pred_taken carried down with the instruction
//  ex_pred_target in   32  pred_target carried down with the instruction
//  mispredict     out  1   flush IF/ID and redirect this cycle
//  redirect_pc    out  32  correct next PC when mispredict=1
//  br_count       out  32  resolved branches/jumps (wraps)
//  mp_count       out  32  mispredicts (wraps)
// BEHAVIOUR
//  - Entry = {valid, tag, target[31:0], is_jump, ctr[1:0]}; rst clears all valid, counters 0.
//  - Lookup comb. from if_pc: hit = valid & tag match; pred_taken = hit & (is_jump | ctr[1]);
//    pred_target = pred_taken ? target : if_pc+4. After reset: pred_taken=0, target=if_pc+4.
//  - actual = ex_br_op[4] | (ex_br_op[4:3]!=00 & ex_taken); correct = actual ? ex_target : ex_pc+4.
//  - mispredict (comb.) = ex_valid & (ex_pred_taken!=actual | (actual & ex_pred_target!=ex_target)).
//  - redirect_pc = correct (don't care when mispredict=0, driven anyway). mispredict=0 in reset.
//  - Updates happen on clk edge when ex_valid; index/tag from ex_pc:
//    * Jump (br_op[4]=1): write valid, tag, target=ex_target, is_jump=1, ctr=11.
//    * Conditional branch, hit: ctr +1 if taken (sat 11), -1 if not (sat 00); target=ex_target
//      if taken; is_jump=0.
//    * Conditional branch, miss: taken -> allocate (ctr=10, is_jump=0); not taken -> no write.
//    * Non-branch (br_op[4:3]=00) with ex_pred_taken=1 (tag alias): invalidate entry.
//  - br_count +1 per ex_valid with br_op[4:3]!=00; mp_count +1 per mispredict cycle.
//  - Same-cycle IF read and EX write to same index: IF sees pre-update value (no bypass).
//  - rst mid-operation: table and counters cleared immediately; no partial write survives.
// TESTING
//  1 After rst, if_pc=0x100 -> pred_taken=0, pred_target=0x104; counters 0.
//  2 BEQ @0x200 taken->0x180, not predicted: mispredict=1, redirect=0x180; next if_pc=0x200
//    -> pred_taken=1, pred_target=0x180 (ctr=10).
//  3 Same BEQ then not taken twice: 1st -> mispredict, redirect 0x204, ctr=01; 2nd -> no mispredict.
//  4 JAL @0x300->0x400 twice: 1st mispredict, 2nd predicted correctly; br_count=2, mp_count=1.
//  5 JALR @0x500 predicted 0x600, actual 0x640 -> mispredict, redirect=0x640, target updated.
//  6 ADD @0x200 with ex_pred_taken=1 -> mispredict, redirect=0x204, entry invalidated; assert
//    rst during EX write -> entry not written, all outputs reset.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: fetch-side next-PC prediction from a direct-mapped BTB with 2-bit
// saturating counters, plus EX-side mispredict detection, redirect and table training.
// Ports:
//   clk, rst                 clock (rising edge) and asynchronous active-high reset
//   if_pc                    fetch PC; pred_taken / pred_target are combinational from it
//   ex_valid, ex_pc,         resolved instruction in EX: BrOp, branch-unit decision and
//   ex_br_op, ex_taken,      computed target, plus the prediction that travelled with it
//   ex_target, ex_pred_*
//   mispredict, redirect_pc  combinational flush request and corrected next PC
//   br_count, mp_count       free-running (wrapping) resolved-branch and mispredict counters
module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [4:0]  ex_br_op,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] mp_count
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_LO  = IDX_BITS + 2;
  localparam int TAG_HI  = IDX_BITS + TAG_BITS + 1;

  // ---------------------------------------------------------------------------
  // BTB storage. Only valid bits and counters carry reset; tag/target/is_jump
  // are meaningless while the valid bit is clear.
  // ---------------------------------------------------------------------------
  logic [ENTRIES-1:0]  valid_q;
  logic [1:0]          ctr_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [31:0]         tgt_q [ENTRIES];
  logic                jmp_q [ENTRIES];

  // ---------------------------------------------------------------------------
  // Fetch-side lookup
  // ---------------------------------------------------------------------------
  logic [IDX_BITS-1:0] if_idx;
  logic [TAG_BITS-1:0] if_tag;
  logic                if_hit;
  logic [31:0]         if_pc_plus4;

  assign if_idx      = if_pc[TAG_LO-1:2];
  assign if_tag      = if_pc[TAG_HI:TAG_LO];
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign if_pc_plus4 = if_pc + 32'd4;

  // A jump entry is always taken; a conditional entry follows the counter MSB.
  assign pred_taken  = if_hit && (jmp_q[if_idx] || ctr_q[if_idx][1]);
  assign pred_target = pred_taken ? tgt_q[if_idx] : if_pc_plus4;

  // ---------------------------------------------------------------------------
  // EX-side resolution
  // ---------------------------------------------------------------------------
  logic [IDX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0] ex_tag;
  logic                ex_hit;
  logic                ex_is_jump;
  logic                ex_is_branch;
  logic                ex_is_cond;
  logic                ex_actual;
  logic [31:0]         ex_pc_plus4;
  logic [31:0]         ex_correct;
  logic                ex_dir_wrong;
  logic                ex_tgt_wrong;

  assign ex_idx       = ex_pc[TAG_LO-1:2];
  assign ex_tag       = ex_pc[TAG_HI:TAG_LO];
  assign ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_is_jump   = ex_br_op[4];
  assign ex_is_branch = (ex_br_op[4:3] != 2'b00);
  assign ex_is_cond   = ex_is_branch && !ex_is_jump;
  assign ex_actual    = ex_is_jump || (ex_is_branch && ex_taken);
  assign ex_pc_plus4  = ex_pc + 32'd4;
  assign ex_correct   = ex_actual ? ex_target : ex_pc_plus4;

  // Direction wrong, or direction right (taken) but predicted to the wrong place.
  assign ex_dir_wrong = (ex_pred_taken != ex_actual);
  assign ex_tgt_wrong = ex_actual && (ex_pred_target != ex_target);

  // Suppressed during reset so fetch never sees a redirect while the table clears.
  assign mispredict  = !rst && ex_valid && (ex_dir_wrong || ex_tgt_wrong);
  assign redirect_pc = ex_correct;

  // ---------------------------------------------------------------------------
  // Training: compute the full new entry at ex_idx, write it with one enable.
  // Fields not being changed default to their current contents.
  // ---------------------------------------------------------------------------
  logic                wr_en;
  logic                wr_valid;
  logic [TAG_BITS-1:0] wr_tag;
  logic [31:0]         wr_tgt;
  logic                wr_jmp;
  logic [1:0]          wr_ctr;

  always_comb begin
    wr_en    = 1'b0;
    wr_valid = valid_q[ex_idx];
    wr_tag   = ex_tag;
    wr_tgt   = tgt_q[ex_idx];
    wr_jmp   = jmp_q[ex_idx];
    wr_ctr   = ctr_q[ex_idx];
    if (ex_valid && !rst) begin
      if (ex_is_jump) begin
        wr_en    = 1'b1;
        wr_valid = 1'b1;
        wr_tgt   = ex_target;
        wr_jmp   = 1'b1;
        wr_ctr   = 2'b11;
      end else if (ex_is_cond) begin
        if (ex_hit) begin
          wr_en    = 1'b1;
          wr_valid = 1'b1;
          wr_jmp   = 1'b0;
          if (ex_taken) begin
            wr_tgt = ex_target;
            if (ctr_q[ex_idx] != 2'b11) wr_ctr = ctr_q[ex_idx] + 2'b01;
          end else begin
            if (ctr_q[ex_idx] != 2'b00) wr_ctr = ctr_q[ex_idx] - 2'b01;
          end
        end else if (ex_taken) begin
          // Allocate weakly taken; a not-taken miss leaves the table alone.
          wr_en    = 1'b1;
          wr_valid = 1'b1;
          wr_tgt   = ex_target;
          wr_jmp   = 1'b0;
          wr_ctr   = 2'b10;
        end
      end else if (ex_pred_taken) begin
        // A non-branch predicted taken means a partial-tag alias: drop the entry.
        wr_en    = 1'b1;
        wr_valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b00;
    end else if (wr_en) begin
      valid_q[ex_idx] <= wr_valid;
      ctr_q[ex_idx]   <= wr_ctr;
    end
  end

  // wr_en is already low during reset, so no write can land in these fields.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[ex_idx] <= wr_tag;
      tgt_q[ex_idx] <= wr_tgt;
      jmp_q[ex_idx] <= wr_jmp;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics counters (wrap naturally at 2**32)
  // ---------------------------------------------------------------------------
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mp_cnt_q, mp_cnt_d;

  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (ex_valid && ex_is_branch) br_cnt_d = br_cnt_q + 32'd1;
    if (mispredict)               mp_cnt_d = mp_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign br_count = br_cnt_q;
  assign mp_count = mp_cnt_q;

  // PC bits outside index/tag and the BrOp sub-opcode are not used by prediction.
  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], if_pc[31:TAG_HI+1],
                         ex_pc[1:0], ex_pc[31:TAG_HI+1], ex_br_op[2:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed test of branch_predictor covering reset state,
// conditional-branch allocate/train, jumps, target mispredicts, alias invalidation
// and reset asserted during an EX write.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_br_op;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] mp_count;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  localparam logic [4:0] OP_NONE = 5'b00000;
  localparam logic [4:0] OP_BEQ  = 5'b01000;
  localparam logic [4:0] OP_JAL  = 5'b10000;
  localparam logic [4:0] OP_JALR = 5'b11000;

  branch_predictor #(.IDX_BITS(6), .TAG_BITS(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_br_op       (ex_br_op),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .br_count       (br_count),
    .mp_count       (mp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [31:0] pc, input logic [4:0] op, input logic tk,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    ex_valid       = 1'b1;
    ex_pc          = pc;
    ex_br_op       = op;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
  endtask

  initial begin
    rst = 1'b1;
    if_pc = 32'h100;
    ex_valid = 1'b0; ex_pc = '0; ex_br_op = OP_NONE; ex_taken = 1'b0;
    ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;

    // 1: reset state
    #3;
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_pred_target", pred_target, 32'h104);
    chk("rst_br_count", br_count, 0);
    chk("rst_mp_count", mp_count, 0);
    drive_ex(32'h200, OP_NONE, 1'b0, 32'h0, 1'b1, 32'h180);
    #1;
    chk("rst_mispredict_gated", mispredict, 0);
    ex_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    tick();

    // 2: BEQ @0x200 taken -> 0x180, not predicted; IF same index sees old value
    drive_ex(32'h200, OP_BEQ, 1'b1, 32'h180, 1'b0, 32'h204);
    if_pc = 32'h200;
    #1;
    chk("beq1_mispredict", mispredict, 1);
    chk("beq1_redirect", redirect_pc, 32'h180);
    chk("beq1_no_bypass_taken", pred_taken, 0);
    chk("beq1_no_bypass_target", pred_target, 32'h204);
    tick(); ex_valid = 1'b0; #1;
    chk("beq1_pred_taken", pred_taken, 1);
    chk("beq1_pred_target", pred_target, 32'h180);
    chk("beq1_br_count", br_count, 1);
    chk("beq1_mp_count", mp_count, 1);

    // 3: same BEQ not taken twice (ctr 10 -> 01 -> 00)
    drive_ex(32'h200, OP_BEQ, 1'b0, 32'h180, 1'b1, 32'h180);
    #1;
    chk("beq2_mispredict", mispredict, 1);
    chk("beq2_redirect", redirect_pc, 32'h204);
    tick(); ex_valid = 1'b0; #1;
    chk("beq2_pred_taken", pred_taken, 0);
    chk("beq2_pred_target", pred_target, 32'h204);
    drive_ex(32'h200, OP_BEQ, 1'b0, 32'h180, 1'b0, 32'h204);
    #1;
    chk("beq3_mispredict", mispredict, 0);
    chk("beq3_redirect", redirect_pc, 32'h204);
    tick(); ex_valid = 1'b0; #1;
    chk("beq3_br_count", br_count, 3);
    chk("beq3_mp_count", mp_count, 2);
    chk("beq3_pred_taken", pred_taken, 0);

    // ex_valid low masks a would-be mispredict
    ex_valid = 1'b0; ex_br_op = OP_NONE; ex_pred_taken = 1'b1;
    #1;
    chk("invalid_ex_mispredict", mispredict, 0);
    tick(); #1;
    chk("invalid_ex_mp_count", mp_count, 2);

    // Fresh start for the jump tests
    rst = 1'b1;
    #1;
    chk("rst2_br_count", br_count, 0);
    chk("rst2_pred_taken", pred_taken, 0);
    @(negedge clk) rst = 1'b0;
    tick();

    // 4: JAL @0x300 -> 0x400 twice
    drive_ex(32'h300, OP_JAL, 1'b1, 32'h400, 1'b0, 32'h304);
    if_pc = 32'h300;
    #1;
    chk("jal1_mispredict", mispredict, 1);
    chk("jal1_redirect", redirect_pc, 32'h400);
    tick(); ex_valid = 1'b0; #1;
    chk("jal1_pred_taken", pred_taken, 1);
    chk("jal1_pred_target", pred_target, 32'h400);
    if_pc = 32'h200;
    #1;
    chk("alias_tag_miss", pred_taken, 0);
    drive_ex(32'h300, OP_JAL, 1'b1, 32'h400, 1'b1, 32'h400);
    #1;
    chk("jal2_mispredict", mispredict, 0);
    tick(); ex_valid = 1'b0; #1;
    chk("jal2_br_count", br_count, 2);
    chk("jal2_mp_count", mp_count, 1);

    // 5: JALR @0x500 learns 0x600, then goes to 0x640 while predicted 0x600
    drive_ex(32'h500, OP_JALR, 1'b1, 32'h600, 1'b0, 32'h504);
    tick(); ex_valid = 1'b0;
    if_pc = 32'h500;
    #1;
    chk("jalr1_pred_target", pred_target, 32'h600);
    drive_ex(32'h500, OP_JALR, 1'b1, 32'h640, 1'b1, 32'h600);
    #1;
    chk("jalr2_mispredict", mispredict, 1);
    chk("jalr2_redirect", redirect_pc, 32'h640);
    tick(); ex_valid = 1'b0; #1;
    chk("jalr2_pred_target", pred_target, 32'h640);
    chk("jalr2_br_count", br_count, 4);
    chk("jalr2_mp_count", mp_count, 3);

    // 6: BEQ re-allocates 0x200, then ADD @0x200 predicted taken invalidates it
    drive_ex(32'h200, OP_BEQ, 1'b1, 32'h180, 1'b0, 32'h204);
    tick(); ex_valid = 1'b0;
    if_pc = 32'h200;
    #1;
    chk("beq4_pred_taken", pred_taken, 1);
    drive_ex(32'h200, OP_NONE, 1'b0, 32'h0, 1'b1, 32'h180);
    #1;
    chk("add_mispredict", mispredict, 1);
    chk("add_redirect", redirect_pc, 32'h204);
    tick(); ex_valid = 1'b0; #1;
    chk("add_invalidated", pred_taken, 0);
    chk("add_pred_target", pred_target, 32'h204);
    chk("add_br_count", br_count, 5);
    chk("add_mp_count", mp_count, 5);

    // Reset asserted while a JAL write is pending in EX
    drive_ex(32'h300, OP_JAL, 1'b1, 32'h400, 1'b0, 32'h304);
    #1;
    rst = 1'b1;
    #1;
    chk("rstw_mispredict", mispredict, 0);
    chk("rstw_br_count", br_count, 0);
    chk("rstw_mp_count", mp_count, 0);
    tick(); ex_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    if_pc = 32'h300;
    #1;
    chk("rstw_no_write_taken", pred_taken, 0);
    chk("rstw_no_write_target", pred_target, 32'h304);
    if_pc = 32'h500;
    #1;
    chk("rstw_table_cleared", pred_taken, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
